// File: rtl/output_queue_pkg.sv
// Shared types for the cipher output queue: status encoding and a helper that
// derives the status from an occupancy value.
package output_queue_pkg;

    typedef enum logic [1:0] {
        OQ_EMPTY = 2'd0,
        OQ_READY = 2'd1,
        OQ_FULL  = 2'd2
    } output_queue_state_t;

    function automatic output_queue_state_t oq_state_of(input int unsigned cnt,
                                                        input int unsigned depth);
        if (cnt == 0)
            return OQ_EMPTY;
        else if (cnt >= depth)
            return OQ_FULL;
        else
            return OQ_READY;
    endfunction

endpackage

// File: rtl/output_queue_if.sv
// Bundle between encryption block / interface FSM (master) and the output queue (slave).
// Strobes flow towards the queue; head word and status flow back.
interface output_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) ();
    import output_queue_pkg::*;

    logic [DATA_W-1:0]          data_in;
    logic                       data_in_pulse;
    logic                       rd_ack;
    logic                       flush;
    logic [DATA_W-1:0]          data_out;
    output_queue_state_t        state_out;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;

    modport master (
        output data_in, data_in_pulse, rd_ack, flush,
        input  data_out, state_out, count, overflow
    );

    modport slave (
        input  data_in, data_in_pulse, rd_ack, flush,
        output data_out, state_out, count, overflow
    );
endinterface

// File: rtl/output_queue.sv
// Circular FIFO holding pulsed cipher outputs until the host acks each read.
// Head is first-word-fall-through and visible the cycle after the push edge.
module output_queue
    import output_queue_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic           clk,
    input  logic           nrst,
    output_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
    logic [CNT_W-1:0]    count_r, count_nx;
    logic [DATA_W-1:0]   data_r, data_nx;
    output_queue_state_t state_r, state_nx;
    logic                ovf_r, ovf_nx;
    logic                empty, full, do_pop, wr_en, rd_adv;

    assign empty = (count_r == '0);
    assign full  = (count_r == FULL_CNT);

    always_comb begin
        do_pop    = q.rd_ack & ~empty;
        // A full queue still accepts a push when a pop frees a slot the same cycle.
        wr_en     = q.data_in_pulse & (~full | do_pop | OVERWRITE);
        rd_adv    = do_pop | (q.data_in_pulse & full & ~do_pop & OVERWRITE);
        rd_ptr_nx = rd_ptr;
        wr_ptr_nx = wr_ptr;
        count_nx  = count_r;
        ovf_nx    = ovf_r;
        data_nx   = '0;
        state_nx  = OQ_EMPTY;

        if (q.flush) begin
            wr_en     = 1'b0;
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
            count_nx  = '0;
            ovf_nx    = 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_nx = wr_ptr + PTR_W'(1);
            if (rd_adv)
                rd_ptr_nx = rd_ptr + PTR_W'(1);
            count_nx = count_r + CNT_W'(wr_en) - CNT_W'(rd_adv);
            if (q.data_in_pulse & full & ~do_pop)
                ovf_nx = 1'b1;
            if (count_nx != '0) begin
                // Bypass covers the word landing in the new head slot this same edge.
                if (wr_en && (wr_ptr == rd_ptr_nx))
                    data_nx = q.data_in;
                else
                    data_nx = mem[rd_ptr_nx];
            end
        end
        state_nx = oq_state_of(32'(count_nx), DEPTH);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= q.data_in;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
            data_r  <= '0;
            state_r <= OQ_EMPTY;
            ovf_r   <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr_nx;
            wr_ptr  <= wr_ptr_nx;
            count_r <= count_nx;
            data_r  <= data_nx;
            state_r <= state_nx;
            ovf_r   <= ovf_nx;
        end
    end

    assign q.data_out  = data_r;
    assign q.state_out = state_r;
    assign q.count     = count_r;
    assign q.overflow  = ovf_r;

    a_count_bound: assert property (@(posedge clk) disable iff (!nrst) count_r <= FULL_CNT);
    a_state_match: assert property (@(posedge clk) disable iff (!nrst)
                                    state_r == oq_state_of(32'(count_r), DEPTH));

endmodule
